// File: rtl/quad_enc_ctrl.sv
// quad_enc_ctrl: rotary encoder + push-key front end.
// Synchronizes and glitch-filters the A/B pins, decodes full quadrature detents,
// keeps a bounded up/down position register, and debounces the key, which
// reloads the register.
//
// Ports:
//   clk       in   single clock
//   rst       in   asynchronous active-high reset
//   enc_a     in   encoder A pin (asynchronous)
//   enc_b     in   encoder B pin (asynchronous)
//   key       in   push key, 1 = pressed (asynchronous)
//   cnt       out  position register
//   cnt_vld   out  one-cycle pulse when cnt changes or is reloaded
//   dir       out  direction of last accepted detent, 0 = CW, 1 = CCW
//   key_lvl   out  debounced key level
//   key_press out  one-cycle pulse on rising edge of key_lvl
module quad_enc_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CNT_MIN  = 0,
    parameter int unsigned CNT_MAX  = 255,
    parameter int unsigned CNT_INIT = 0,
    parameter int unsigned WRAP     = 0,
    parameter int unsigned FILT_CYC = 4,
    parameter int unsigned DEB_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             key,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_vld,
    output logic             dir,
    output logic             key_lvl,
    output logic             key_press
);

    localparam int unsigned FILT_W = $clog2(FILT_CYC + 1);
    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);

    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(CNT_INIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CW1,
        ST_CW2,
        ST_CW3,
        ST_CCW1,
        ST_CCW2,
        ST_CCW3,
        ST_WAIT
    } dec_state_t;

    // bit 1 = A, bit 0 = B
    logic [1:0]        ab_s1;
    logic [1:0]        ab_s2;
    logic [1:0]        ab_f;
    logic [FILT_W-1:0] fcnt [2];

    logic              key_s1;
    logic              key_s2;
    logic [DEB_W-1:0]  kcnt;

    dec_state_t        state;
    logic              det_cw;
    logic              det_ccw;

    // Two-stage synchronizers for all asynchronous pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_s1  <= 2'b00;
            ab_s2  <= 2'b00;
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
        end else begin
            ab_s1  <= {enc_a, enc_b};
            ab_s2  <= ab_s1;
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // Per-pin stability filter: follow the synced pin after FILT_CYC disagreeing cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_f <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ab_s2[i] == ab_f[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_W'(FILT_CYC - 1)) begin
                    ab_f[i] <= ab_s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FILT_W'(1);
                end
            end
        end
    end

    // Quadrature decoder; a detent is emitted only on the final step back to 00
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            det_cw  <= 1'b0;
            det_ccw <= 1'b0;
        end else begin
            det_cw  <= 1'b0;
            det_ccw <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (ab_f)
                        2'b10:   state <= ST_CW1;
                        2'b01:   state <= ST_CCW1;
                        2'b11:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_CW1: begin
                    case (ab_f)
                        2'b11:   state <= ST_CW2;
                        2'b00:   state <= ST_IDLE;
                        2'b01:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_CW2: begin
                    case (ab_f)
                        2'b01:   state <= ST_CW3;
                        2'b10:   state <= ST_CW1;
                        2'b00:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_CW3: begin
                    case (ab_f)
                        2'b00: begin
                            state  <= ST_IDLE;
                            det_cw <= 1'b1;
                        end
                        2'b11:   state <= ST_CW2;
                        2'b10:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_CCW1: begin
                    case (ab_f)
                        2'b11:   state <= ST_CCW2;
                        2'b00:   state <= ST_IDLE;
                        2'b10:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_CCW2: begin
                    case (ab_f)
                        2'b10:   state <= ST_CCW3;
                        2'b01:   state <= ST_CCW1;
                        2'b00:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_CCW3: begin
                    case (ab_f)
                        2'b00: begin
                            state   <= ST_IDLE;
                            det_ccw <= 1'b1;
                        end
                        2'b11:   state <= ST_CCW2;
                        2'b01:   state <= ST_WAIT;
                        default: ;
                    endcase
                end
                ST_WAIT: begin
                    if (ab_f == 2'b00) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Key debounce: level follows the synced key once it disagrees past DEB_CYC cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kcnt      <= '0;
            key_lvl   <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (key_s2 == key_lvl) begin
                kcnt <= '0;
            end else if (kcnt == DEB_W'(DEB_CYC)) begin
                kcnt      <= '0;
                key_lvl   <= key_s2;
                key_press <= key_s2;
            end else begin
                kcnt <= kcnt + DEB_W'(1);
            end
        end
    end

    // Position register; a key reload overrides a detent in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= INIT_V;
            cnt_vld <= 1'b0;
            dir     <= 1'b0;
        end else begin
            cnt_vld <= 1'b0;
            if (key_press) begin
                cnt     <= INIT_V;
                cnt_vld <= 1'b1;
            end else if (det_cw) begin
                dir <= 1'b0;
                if (cnt == MAX_V) begin
                    if (WRAP != 0) begin
                        cnt     <= MIN_V;
                        cnt_vld <= 1'b1;
                    end
                end else begin
                    cnt     <= cnt + CNT_W'(1);
                    cnt_vld <= 1'b1;
                end
            end else if (det_ccw) begin
                dir <= 1'b1;
                if (cnt == MIN_V) begin
                    if (WRAP != 0) begin
                        cnt     <= MAX_V;
                        cnt_vld <= 1'b1;
                    end
                end else begin
                    cnt     <= cnt - CNT_W'(1);
                    cnt_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// tb_quad_enc_ctrl: directed bench for quad_enc_ctrl. Two instances share the
// pins: one saturating, one wrapping. A detent-level model predicts every output
// on every cycle; literal checks pin the model at key points.
module tb_quad_enc_ctrl;

    localparam int F    = 4;
    localparam int D    = 50;
    localparam int INIT = 0;
    localparam int CMIN = 0;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enc_a = 1'b0;
    logic       enc_b = 1'b0;
    logic       key = 1'b0;
    logic [7:0] cnt0, cnt1;
    logic       vld0, vld1, dir0, dir1, kl0, kl1, kp0, kp1;

    quad_enc_ctrl #(
        .CNT_W(8), .CNT_MIN(CMIN), .CNT_MAX(CMAX), .CNT_INIT(INIT),
        .WRAP(0), .FILT_CYC(F), .DEB_CYC(D)
    ) u_sat (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .key(key),
        .cnt(cnt0), .cnt_vld(vld0), .dir(dir0), .key_lvl(kl0), .key_press(kp0)
    );

    quad_enc_ctrl #(
        .CNT_W(8), .CNT_MIN(CMIN), .CNT_MAX(CMAX), .CNT_INIT(INIT),
        .WRAP(1), .FILT_CYC(F), .DEB_CYC(D)
    ) u_wrap (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .key(key),
        .cnt(cnt1), .cnt_vld(vld1), .dir(dir1), .key_lvl(kl1), .key_press(kp1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Model state: detent/reload/key events keyed by the cycle they become visible
    int         m_cnt0 = INIT;
    int         m_cnt1 = INIT;
    bit         m_dir = 1'b0;
    bit         m_kl = 1'b0;
    int         det_at [int];
    bit         rel_at [int];
    bit         kl_at  [int];
    bit         kp_at  [int];
    int         acc = 0;
    bit         inval = 1'b0;
    logic [1:0] m_ab = 2'b00;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;
    int vld_cnt0 = 0;
    int vld_cnt1 = 0;
    int kp_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int step_cnt(input int c, input int d, input bit wrap);
        int n;
        n = c + d;
        if (n > CMAX) n = wrap ? CMIN : CMAX;
        if (n < CMIN) n = wrap ? CMAX : CMIN;
        return n;
    endfunction

    // Quadrature as a position walk: a clean +-4 excursion back to 00 is one detent
    task automatic model_ab(input logic [1:0] ab, input int k);
        int d;
        d = (pos_of(ab) - pos_of(m_ab) + 4) % 4;
        if (d == 2) inval = 1'b1;
        else if (d == 1) acc++;
        else if (d == 3) acc--;
        m_ab = ab;
        if (ab == 2'b00) begin
            if (!inval && acc == 4) det_at[k + F + 4] = 1;
            else if (!inval && acc == -4) det_at[k + F + 4] = -1;
            acc = 0;
            inval = 1'b0;
        end
    endtask

    task automatic step_ab(input logic [1:0] ab, input int hold);
        @(posedge clk); #1;
        {enc_a, enc_b} = ab;
        model_ab(ab, cyc);
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic cw(input int h);
        step_ab(2'b10, h); step_ab(2'b11, h); step_ab(2'b01, h); step_ab(2'b00, h);
    endtask

    task automatic ccw(input int h);
        step_ab(2'b01, h); step_ab(2'b11, h); step_ab(2'b10, h); step_ab(2'b00, h);
    endtask

    // settle=1 promises the level is held well past the debounce window
    task automatic key_set(input bit v, input bit settle, input int hold);
        @(posedge clk); #1;
        key = v;
        if (settle) begin
            kl_at[cyc + D + 3] = v;
            if (v) begin
                kp_at[cyc + D + 3]  = 1'b1;
                rel_at[cyc + D + 4] = 1'b1;
            end
        end
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        bit e_vld0, e_vld1, e_kp;
        int n;
        if (chk_en) begin
            e_vld0 = 1'b0;
            e_vld1 = 1'b0;
            if (rel_at.exists(cyc)) begin
                m_cnt0 = INIT;
                m_cnt1 = INIT;
                e_vld0 = 1'b1;
                e_vld1 = 1'b1;
            end else if (det_at.exists(cyc)) begin
                m_dir = (det_at[cyc] < 0);
                n = step_cnt(m_cnt0, det_at[cyc], 1'b0);
                e_vld0 = (n != m_cnt0);
                m_cnt0 = n;
                n = step_cnt(m_cnt1, det_at[cyc], 1'b1);
                e_vld1 = (n != m_cnt1);
                m_cnt1 = n;
            end
            if (kl_at.exists(cyc)) m_kl = kl_at[cyc];
            e_kp = kp_at.exists(cyc);
            check("cnt_sat", int'(cnt0), m_cnt0);
            check("cnt_wrap", int'(cnt1), m_cnt1);
            check("vld_sat", int'(vld0), int'(e_vld0));
            check("vld_wrap", int'(vld1), int'(e_vld1));
            check("dir_sat", int'(dir0), int'(m_dir));
            check("dir_wrap", int'(dir1), int'(m_dir));
            check("key_lvl", int'(kl0), int'(m_kl));
            check("key_lvl_w", int'(kl1), int'(m_kl));
            check("key_press", int'(kp0), int'(e_kp));
            check("key_press_w", int'(kp1), int'(e_kp));
            if (vld0) vld_cnt0++;
            if (vld1) vld_cnt1++;
            if (kp0) kp_cnt++;
        end
    end

    initial begin
        #1;
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_cnt", int'(cnt0), 0);
        check("rst_vld", int'(vld0), 0);
        check("rst_dir", int'(dir0), 0);
        check("rst_key_lvl", int'(kl0), 0);
        idle(5);

        // Three CW detents, quadrature period 20
        vld_cnt0 = 0;
        repeat (3) cw(5);
        idle(12);
        check("cw3_cnt", int'(cnt0), 3);
        check("cw3_pulses", vld_cnt0, 3);
        check("cw3_dir", int'(dir0), 0);

        // Asynchronous reset mid-cycle
        @(posedge clk); #3;
        rst = 1'b1;
        det_at.delete(); rel_at.delete(); kl_at.delete(); kp_at.delete();
        m_cnt0 = INIT; m_cnt1 = INIT; m_dir = 1'b0; m_kl = 1'b0;
        acc = 0; inval = 1'b0; m_ab = {enc_a, enc_b};
        #1;
        check("async_rst_cnt", int'(cnt0), 0);
        check("async_rst_cnt_w", int'(cnt1), 0);
        check("async_rst_vld", int'(vld0), 0);
        check("async_rst_dir", int'(dir0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // One CW then three CCW: saturate at 0 vs wrap to 255 and on
        cw(8);
        idle(12);
        vld_cnt0 = 0; vld_cnt1 = 0;
        repeat (3) ccw(8);
        idle(12);
        check("sat_cnt", int'(cnt0), 0);
        check("sat_pulses", vld_cnt0, 1);
        check("sat_dir", int'(dir0), 1);
        check("wrap_cnt", int'(cnt1), 254);
        check("wrap_pulses", vld_cnt1, 3);

        // Short glitch on A is filtered out
        vld_cnt0 = 0;
        @(posedge clk); #1; enc_a = 1'b1;
        repeat (2) @(posedge clk);
        #1; enc_a = 1'b0;
        idle(20);
        // Back-step: A up, B up, B down, A down
        step_ab(2'b10, 8); step_ab(2'b11, 8); step_ab(2'b10, 8); step_ab(2'b00, 8);
        idle(12);
        check("noise_cnt", int'(cnt0), 0);
        check("noise_pulses", vld_cnt0, 0);
        check("noise_cnt_w", int'(cnt1), 254);

        // A and B together -> WAIT, then a clean CW counts once
        step_ab(2'b11, 10); step_ab(2'b00, 10);
        cw(8);
        idle(12);
        check("ab_same_cnt", int'(cnt0), 1);
        check("ab_same_pulses", vld_cnt0, 1);
        check("ab_same_cnt_w", int'(cnt1), 255);

        // Key bounce then a long press: one press, one reload
        vld_cnt0 = 0; vld_cnt1 = 0; kp_cnt = 0;
        for (int i = 0; i < 29; i++) begin
            key_set(1'b0, 1'b0, 11);
            key_set(1'b1, 1'b0, 14);
        end
        key_set(1'b0, 1'b0, 11);
        key_set(1'b1, 1'b1, 200);
        #1;
        check("bounce_presses", kp_cnt, 1);
        check("bounce_key_lvl", int'(kl0), 1);
        check("reload_cnt", int'(cnt0), 0);
        check("reload_cnt_w", int'(cnt1), 0);
        check("reload_pulses", vld_cnt0, 1);
        check("reload_pulses_w", vld_cnt1, 1);
        key_set(1'b0, 1'b1, 70);
        #1;
        check("release_key_lvl", int'(kl0), 0);
        check("release_presses", kp_cnt, 1);

        // Collision: key_press lands on the same cycle as a CW detent
        cw(8);
        idle(12);
        check("pre_coll_cnt", int'(cnt0), 1);
        vld_cnt0 = 0;
        key_set(1'b1, 1'b1, 1);
        step_ab(2'b10, 15); step_ab(2'b11, 15); step_ab(2'b01, 15); step_ab(2'b00, 15);
        idle(10);
        check("coll_cnt", int'(cnt0), 0);
        check("coll_cnt_w", int'(cnt1), 0);
        check("coll_pulses", vld_cnt0, 1);
        key_set(1'b0, 1'b1, 70);
        cw(8);
        idle(12);
        check("post_coll_cnt", int'(cnt0), 1);
        check("post_coll_cnt_w", int'(cnt1), 1);
        check("post_coll_dir", int'(dir0), 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
